// File: rtl/cpu_loader_if.sv
// cpu_loader_if: bundles every non-clock signal of cpu_loader.
//   UART side : rx_byte/received in, tx_byte/transmit out, is_transmitting in
//   CPU side  : cpu_tx_byte/cpu_transmit, cpu_raddr/cpu_waddr/cpu_dwrite/
//               cpu_write_en, cpu_halted in; cpu_go/startaddr/cpu_owns out
//   RAM side  : ram_raddr/ram_waddr/ram_dwrite/ram_write_en out, ram_dread in
// modport master is the loader; modport slave is everything around it.
interface cpu_loader_if #(parameter int addr_width = 9);
  logic [7:0]            rx_byte;
  logic                  received;
  logic                  is_transmitting;
  logic [7:0]            tx_byte;
  logic                  transmit;
  logic [7:0]            cpu_tx_byte;
  logic                  cpu_transmit;
  logic [addr_width-1:0] cpu_raddr;
  logic [addr_width-1:0] cpu_waddr;
  logic [7:0]            cpu_dwrite;
  logic                  cpu_write_en;
  logic                  cpu_halted;
  logic                  cpu_go;
  logic [addr_width-1:0] startaddr;
  logic [addr_width-1:0] ram_raddr;
  logic [addr_width-1:0] ram_waddr;
  logic [7:0]            ram_dwrite;
  logic                  ram_write_en;
  logic [7:0]            ram_dread;
  logic                  cpu_owns;

  modport master (
    input  rx_byte, received, is_transmitting,
    input  cpu_tx_byte, cpu_transmit, cpu_raddr, cpu_waddr, cpu_dwrite,
    input  cpu_write_en, cpu_halted, ram_dread,
    output tx_byte, transmit, cpu_go, startaddr,
    output ram_raddr, ram_waddr, ram_dwrite, ram_write_en, cpu_owns
  );

  modport slave (
    output rx_byte, received, is_transmitting,
    output cpu_tx_byte, cpu_transmit, cpu_raddr, cpu_waddr, cpu_dwrite,
    output cpu_write_en, cpu_halted, ram_dread,
    input  tx_byte, transmit, cpu_go, startaddr,
    input  ram_raddr, ram_waddr, ram_dwrite, ram_write_en, cpu_owns
  );
endinterface

// File: rtl/cpu_loader.sv
// cpu_loader: serial monitor and RAM/UART-tx arbiter for the soft CPU.
//   clk   : system clock, rising edge
//   rst   : asynchronous reset, active low
//   bus   : cpu_loader_if.master (UART, CPU and RAM signals)
// Host commands (one byte per received strobe, addr = {hi, lo}):
//   'L' hi lo n data...  write n bytes (n=0 -> 256), reply 0x06
//   'R' hi lo            reply RAM[addr]
//   'G' hi lo            start CPU at addr, reply 'H' when it halts
//   other                reply '?'
// addr_width must be 9..16 and must match the interface instance.
module cpu_loader #(
  parameter int addr_width = 9
) (
  input  logic           clk,
  input  logic           rst,
  cpu_loader_if.master   bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_AHI, S_ALO, S_CNT, S_DATA,
    S_RD1, S_RD2, S_RDCAP, S_GO, S_RUN, S_TXW
  } state_t;

  localparam logic [7:0] CMD_L = 8'h4C;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_G = 8'h47;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h3F;
  localparam logic [7:0] HLT   = 8'h48;

  state_t                state;
  logic [7:0]            cmd;
  logic [addr_width-1:0] addr;
  logic [8:0]            cnt;       // 9 bits so n=0 can mean 256
  logic [addr_width-1:0] l_raddr;
  logic [addr_width-1:0] l_waddr;
  logic [7:0]            l_dwrite;
  logic                  l_we;
  logic [7:0]            l_tx_byte; // doubles as the pending reply byte
  logic                  l_transmit;
  logic                  go_r;
  logic [addr_width-1:0] startaddr_r;
  logic                  owns;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cmd         <= '0;
      addr        <= '0;
      cnt         <= '0;
      l_raddr     <= '0;
      l_waddr     <= '0;
      l_dwrite    <= '0;
      l_we        <= 1'b0;
      l_tx_byte   <= '0;
      l_transmit  <= 1'b0;
      go_r        <= 1'b0;
      startaddr_r <= '0;
      owns        <= 1'b0;
    end else begin
      // one-cycle strobes
      l_we       <= 1'b0;
      l_transmit <= 1'b0;
      go_r       <= 1'b0;
      unique case (state)
        S_IDLE: if (bus.received) begin
          cmd <= bus.rx_byte;
          if (bus.rx_byte == CMD_L || bus.rx_byte == CMD_R || bus.rx_byte == CMD_G)
            state <= S_AHI;
          else begin
            l_tx_byte <= NAK;
            state     <= S_TXW;
          end
        end
        S_AHI: if (bus.received) begin
          // truncating cast keeps only the hi bits that fit the address
          addr  <= addr_width'({bus.rx_byte, 8'h00});
          state <= S_ALO;
        end
        S_ALO: if (bus.received) begin
          addr <= {addr[addr_width-1:8], bus.rx_byte};
          if (cmd == CMD_L)      state <= S_CNT;
          else if (cmd == CMD_R) state <= S_RD1;
          else begin
            // ownership and go rise on the same edge
            startaddr_r <= {addr[addr_width-1:8], bus.rx_byte};
            go_r        <= 1'b1;
            owns        <= 1'b1;
            state       <= S_GO;
          end
        end
        S_CNT: if (bus.received) begin
          cnt   <= (bus.rx_byte == 8'h00) ? 9'd256 : {1'b0, bus.rx_byte};
          state <= S_DATA;
        end
        S_DATA: if (bus.received) begin
          l_waddr  <= addr;
          l_dwrite <= bus.rx_byte;
          l_we     <= 1'b1;
          addr     <= addr + 1'b1;   // wraps modulo 2^addr_width
          cnt      <= cnt - 1'b1;
          if (cnt == 9'd1) begin
            l_tx_byte <= ACK;
            state     <= S_TXW;
          end
        end
        S_RD1: begin
          l_raddr <= addr;
          state   <= S_RD2;
        end
        S_RD2:   state <= S_RDCAP;
        S_RDCAP: begin
          l_tx_byte <= bus.ram_dread;
          state     <= S_TXW;
        end
        S_GO:  state <= S_RUN;
        S_RUN: if (bus.cpu_halted) begin
          // received in this cycle is dropped; halt wins
          owns      <= 1'b0;
          l_tx_byte <= HLT;
          state     <= S_TXW;
        end
        S_TXW: if (!bus.is_transmitting) begin
          l_transmit <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Combinational mux on the current owner; a CPU write in the halt cycle
  // still passes because owns only drops after that edge.
  assign bus.ram_raddr    = owns ? bus.cpu_raddr    : l_raddr;
  assign bus.ram_waddr    = owns ? bus.cpu_waddr    : l_waddr;
  assign bus.ram_dwrite   = owns ? bus.cpu_dwrite   : l_dwrite;
  assign bus.ram_write_en = owns ? bus.cpu_write_en : l_we;
  assign bus.tx_byte      = owns ? bus.cpu_tx_byte  : l_tx_byte;
  assign bus.transmit     = owns ? bus.cpu_transmit : l_transmit;
  assign bus.cpu_go       = go_r;
  assign bus.startaddr    = startaddr_r;
  assign bus.cpu_owns     = owns;

endmodule

// File: tb/tb_cpu_loader.sv
module tb_cpu_loader;
  localparam int AW = 9;

  typedef struct {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   wr_cnt = 0;
  int   tx_cnt = 0;
  logic [7:0] txq[$];
  wr_t        wq[$];
  logic [7:0] mem [0:(1<<AW)-1];

  cpu_loader_if #(.addr_width(AW)) bus ();

  cpu_loader #(.addr_width(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: data for an address registered at edge e is valid after e+1.
  always @(posedge clk) begin
    if (bus.ram_write_en) mem[bus.ram_waddr] <= bus.ram_dwrite;
    bus.ram_dread <= mem[bus.ram_raddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write and transmit seen must match the head of its queue.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.ram_write_en) begin
        wr_cnt++;
        checks++;
        assert (wq.size() != 0) else begin
          failures++;
          $error("FAIL unexp_write observed=%0h:%0h expected=none", bus.ram_waddr, bus.ram_dwrite);
        end
        if (wq.size() != 0) begin
          wr_t e;
          e = wq.pop_front();
          chk("wr_addr", 32'(bus.ram_waddr), 32'(e.a));
          chk("wr_data", 32'(bus.ram_dwrite), 32'(e.d));
        end
      end
      if (bus.transmit) begin
        tx_cnt++;
        checks++;
        assert (txq.size() != 0) else begin
          failures++;
          $error("FAIL unexp_tx observed=%0h expected=none", bus.tx_byte);
        end
        if (txq.size() != 0) chk("tx_byte", 32'(bus.tx_byte), 32'(txq.pop_front()));
      end
    end
  end

  // All tasks start and end at posedge+1.
  task automatic rx_strobe(input logic [7:0] b);
    bus.rx_byte  = b;
    bus.received = 1'b1;
    @(posedge clk); #1;
    bus.received = 1'b0;
  endtask

  task automatic rx(input logic [7:0] b);
    rx_strobe(b);
    @(posedge clk); #1;
  endtask

  task automatic rx_data(input logic [7:0] b);
    rx_strobe(b);
    chk("we_latency", 32'(bus.ram_write_en), 1);
    @(posedge clk); #1;
    chk("we_one_cycle", 32'(bus.ram_write_en), 0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300 && (txq.size() != 0 || wq.size() != 0); i++) @(posedge clk);
    @(posedge clk); #1;
    chk(tag, 32'(txq.size() + wq.size()), 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_owns"},  32'(bus.cpu_owns), 0);
    chk({tag, "_go"},    32'(bus.cpu_go), 0);
    chk({tag, "_tx"},    32'(bus.transmit), 0);
    chk({tag, "_txb"},   32'(bus.tx_byte), 0);
    chk({tag, "_we"},    32'(bus.ram_write_en), 0);
    chk({tag, "_start"}, 32'(bus.startaddr), 0);
    chk({tag, "_raddr"}, 32'(bus.ram_raddr), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int w0, t0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
    bus.rx_byte = '0; bus.received = 0; bus.is_transmitting = 0;
    bus.cpu_tx_byte = '0; bus.cpu_transmit = 0; bus.cpu_raddr = '0;
    bus.cpu_waddr = '0; bus.cpu_dwrite = '0; bus.cpu_write_en = 0;
    bus.cpu_halted = 0;
    // cpu inputs are driven with nonzero values to prove they are not passed in reset
    bus.cpu_raddr = 9'h155; bus.cpu_tx_byte = 8'h99;
    repeat (2) @(posedge clk); #1;
    chk_reset_outs("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // Load 3 bytes at 0x010 and read one back
    txq.push_back(8'h06);
    wq.push_back('{9'h010, 8'hAA});
    wq.push_back('{9'h011, 8'hBB});
    wq.push_back('{9'h012, 8'hCC});
    rx(8'h4C); rx(8'h00); rx(8'h10); rx(8'h03);
    rx_data(8'hAA); rx_data(8'hBB); rx_data(8'hCC);
    drain("load_done");
    txq.push_back(8'hBB);
    rx(8'h52); rx(8'h00); rx(8'h11);
    drain("read_bb");

    // 256-byte load starting at 0x1FF, wrapping to 0x000
    w0 = wr_cnt;
    for (int i = 0; i < 256; i++) wq.push_back('{9'h1FF + 9'(i), 8'(i)});
    txq.push_back(8'h06);
    rx(8'h4C); rx(8'h01); rx(8'hFF); rx(8'h00);
    for (int i = 0; i < 256; i++) rx(8'(i));
    drain("load256_done");
    chk("load256_count", 32'(wr_cnt - w0), 256);

    // Run at 0x100
    rx(8'h47); rx(8'h01); rx_strobe(8'h00);
    chk("go_pulse", 32'(bus.cpu_go), 1);
    chk("go_start", 32'(bus.startaddr), 32'h100);
    chk("go_owns", 32'(bus.cpu_owns), 1);
    @(posedge clk); #1;
    chk("go_one_cycle", 32'(bus.cpu_go), 0);
    chk("run_owns", 32'(bus.cpu_owns), 1);
    bus.cpu_raddr = 9'h1AB;
    #1;
    chk("run_raddr_pass", 32'(bus.ram_raddr), 32'h1AB);

    // Host bytes in RUN are ignored; CPU tx passes through
    w0 = wr_cnt;
    rx(8'h4C); rx(8'h00); rx(8'h00); rx(8'h01); rx(8'h55);
    chk("run_no_writes", 32'(wr_cnt - w0), 0);
    txq.push_back(8'h41);
    bus.cpu_tx_byte = 8'h41; bus.cpu_transmit = 1'b1;
    @(posedge clk); #1;
    bus.cpu_transmit = 1'b0;
    drain("run_cpu_tx");

    // Halt together with a received byte and a CPU write
    wq.push_back('{9'h1F0, 8'h77});
    txq.push_back(8'h48);
    bus.cpu_halted = 1; bus.received = 1; bus.rx_byte = 8'h4C;
    bus.cpu_write_en = 1; bus.cpu_waddr = 9'h1F0; bus.cpu_dwrite = 8'h77;
    @(posedge clk); #1;
    bus.cpu_halted = 0; bus.received = 0; bus.cpu_write_en = 0;
    chk("halt_owns", 32'(bus.cpu_owns), 0);
    drain("halt_reply");
    chk("idle_raddr_loader", 32'(bus.ram_raddr), 32'h011);

    // CPU requests while idle must not reach RAM or UART
    bus.cpu_write_en = 1; bus.cpu_transmit = 1;
    #1;
    chk("idle_we_blocked", 32'(bus.ram_write_en), 0);
    chk("idle_tx_blocked", 32'(bus.transmit), 0);
    @(posedge clk); #1;
    bus.cpu_write_en = 0; bus.cpu_transmit = 0;

    // Bad command under tx backpressure
    bus.is_transmitting = 1;
    txq.push_back(8'h3F);
    t0 = tx_cnt;
    rx(8'h5A);
    repeat (20) @(posedge clk);
    #1;
    chk("bp_held", 32'(tx_cnt - t0), 0);
    bus.is_transmitting = 0;
    drain("bp_reply");
    chk("bp_one_tx", 32'(tx_cnt - t0), 1);

    // Reset after 2 of 5 data bytes
    wq.push_back('{9'h040, 8'h55});
    wq.push_back('{9'h041, 8'h66});
    rx(8'h4C); rx(8'h00); rx(8'h40); rx(8'h05);
    rx(8'h55); rx(8'h66);
    rst = 1'b0;
    #1;
    chk_reset_outs("rst_load");
    @(posedge clk); #1;
    rst = 1'b1;
    t0 = tx_cnt;
    repeat (30) @(posedge clk);
    #1;
    chk("rst_no_ack", 32'(tx_cnt - t0), 0);
    drain("rst_load_q");
    txq.push_back(8'h66);
    rx(8'h52); rx(8'h00); rx(8'h41);
    drain("rst_load_read");

    // Reset during RUN
    rx(8'h47); rx(8'h00); rx(8'h20);
    chk("run2_owns", 32'(bus.cpu_owns), 1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk_reset_outs("rst_run");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    txq.push_back(8'h13);
    rx(8'h52); rx(8'h00); rx(8'h12);
    drain("rst_run_read");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cpu_loader.md
# cpu_loader

Serial monitor and RAM arbiter for the soft CPU. It sits between the UART (rx/tx byte interfaces), the shared program/data RAM and the `cpu` core. While the CPU is idle, it accepts host commands to write a RAM block, read a RAM byte, or start the CPU at an address. While the CPU runs, it hands over the RAM port and the UART tx path, and it reclaims both when the CPU reports `halted`.

## Interface
- `addr_width`, default 9: RAM address width, same as the CPU; must be 9..16.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `rx_byte` in 8: received UART byte; valid while `received`=1.
- `received` in 1: one-cycle strobe, new byte on `rx_byte`.
- `is_transmitting` in 1: UART tx busy.
- `tx_byte` out 8 / `transmit` out 1: to UART; `transmit` is a one-cycle strobe.
- `cpu_tx_byte` in 8 / `cpu_transmit` in 1: CPU tx request, muxed to UART while the CPU owns the bus.
- `cpu_raddr`, `cpu_waddr` in addr_width; `cpu_dwrite` in 8; `cpu_write_en` in 1: CPU RAM requests.
- `cpu_halted` in 1: one-cycle strobe from the CPU on HLT.
- `cpu_go` out 1: one-cycle start strobe to the CPU start input.
- `startaddr` out addr_width: start PC for the CPU; stable while `cpu_go`=1.
- `ram_raddr`, `ram_waddr` out addr_width; `ram_dwrite` out 8; `ram_write_en` out 1: to RAM.
- `ram_dread` in 8: RAM read data; valid 2 cycles after the loader registers its read address.
- `cpu_owns` out 1: 1 while the CPU owns the RAM and tx.

## Operation
- **Arbiter.**
  - `cpu_owns`=1: all `ram_*` outputs and `tx_byte`/`transmit` pass the `cpu_*` inputs through combinationally.
  - `cpu_owns`=0: they carry the loader's registered signals.
  - Non-owner write enables and transmit requests are dropped, never queued.
- **Host protocol.** One byte per `received` strobe. Address = {hi[addr_width-9:0], lo}; the upper hi bits are ignored.
  - `L` (0x4C) hi lo n d0..d(n-1): write n bytes from addr upward. n=0 means 256. The address wraps modulo 2^addr_width. On completion, reply 0x06.
  - `R` (0x52) hi lo: reply with RAM[addr].
  - `G` (0x47) hi lo: set `startaddr`=addr and pulse `cpu_go`. On `cpu_halted`, reply `H` (0x48).
  - Any other command byte: reply `?` (0x3F) and return to IDLE.
- **States.**
  - IDLE: wait for a command byte.
  - AHI, ALO: capture the address bytes.
  - CNT: capture n.
  - DATA: each byte sets ram_waddr=addr, ram_dwrite=byte, ram_write_en=1 for exactly one cycle; then addr+1, remaining-1. After the last byte, go to TXW with 0x06.
  - RD1, RD2, RDCAP: RD1 registers ram_raddr; RDCAP captures `ram_dread` into the tx byte; then go to TXW.
  - GO: `cpu_go`=1 and `cpu_owns`<=1, for one cycle; then go to RUN.
  - RUN: ignore `received`. On `cpu_halted`, set `cpu_owns`<=0 in the same edge and go to TXW with 0x48.
  - TXW: wait for `is_transmitting`=0, then pulse `transmit` with the held byte and return to IDLE.
- A `received` strobe outside IDLE/AHI/ALO/CNT/DATA is discarded. A command byte never aborts an in-progress command.
- The remaining-byte counter is 9 bits, which covers the 256 case.

## Timing
- **Reset values (async, `rst`=0).**
  - State=IDLE; `cpu_owns`=0; `cpu_go`=0; `transmit`=0.
  - `ram_write_en`=0; `tx_byte`=0; `startaddr`=0.
  - Internal addr, count and registered RAM address = 0.
  - Reset mid-command or mid-RUN: the command is abandoned and the CPU loses the bus immediately.
- **Strobes.** `ram_write_en`, `transmit` and `cpu_go` are registered one-cycle strobes, cleared by default every cycle.
- **Write latency.** Data byte strobe at edge k: write asserted after edge k+1.
- **Read latency.** Address register set in RD1; data sampled in RDCAP, 2 edges later.
- **Ownership handover.**
  - `cpu_owns` rises on the same edge that asserts `cpu_go`.
  - It falls on the edge that samples `cpu_halted`=1.
  - A CPU write in the halted cycle is still passed, because the mux is combinational on the pre-edge `cpu_owns`.
- **Simultaneous events.** `cpu_halted` together with `received` in RUN: the halt is taken and the byte is dropped.

## Test plan
- Load and read back: send 4C 00 10 03 AA BB CC, expect 0x06. Then send 52 00 11, expect 0xBB. Check the three writes go to addresses 0x010..0x012, one cycle each.
- Wrap and 256: send 4C 01 FF 00 followed by 256 bytes (i = 0..255). Expect addr 0x1FF gets byte 0 and addr 0x000 gets byte 1. Exactly 256 `ram_write_en` pulses, then 0x06.
- Run and halt: send 47 01 00. Expect `cpu_go` for one cycle with `startaddr`=0x100 and `cpu_owns`=1. Drive `cpu_raddr` and check it reaches `ram_raddr`. Pulse `cpu_halted`; expect `cpu_owns`=0 and tx 0x48.
- Bus isolation: in RUN, inject `received` with 0x4C, then pulse `cpu_transmit` with 0x41. Expect no loader writes and UART tx 0x41. In IDLE, a `cpu_write_en` pulse must not reach `ram_write_en`.
- Bad command and tx backpressure: send 0x5A while `is_transmitting`=1 for 20 cycles. Expect `transmit` only after it drops, with `tx_byte`=0x3F.
- Reset mid-operation: assert `rst`=0 after 2 data bytes of an `L` command, and separately during RUN. Expect immediate return to all reset values and no 0x06 reply. A subsequent `R` command works.
